// File: rtl/pwm_pkg.sv
// Shared defaults and types for the multi-channel PWM generator.
// No logic here; constants and the commit FSM state encoding only.
// No flow control: nothing in this file is clocked.
package pwm_pkg;

  localparam int CHANNELS_DEF = 3;
  localparam int WIDTH_DEF    = 16;
  localparam int PRESCALE_DEF = 1;

  // Full-scale duty for the default width; this value means 100% on time.
  localparam logic [WIDTH_DEF-1:0] DUTY_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/pwm_compare.sv
// One PWM channel: holds the active duty and drives a registered output bit.
// Latency: output reflects (active, cnt_next) one clock later, so it lines up with cnt.
// Backpressure: none; swap is a single-cycle strobe from the commit FSM.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             swap,
  input  logic [WIDTH-1:0] shadow,
  input  logic [WIDTH-1:0] cnt_next,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] FULL = '1;

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] active_next;

  // Compare against the value active will hold after this edge, so the first
  // count of a new period already uses the freshly swapped duty.
  assign active_next = swap ? shadow : active;

  // Active duty register and registered compare; all-ones forces 100% on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      pwm_out <= 1'b0;
    end else begin
      active <= active_next;
      if (active_next == '0) begin
        pwm_out <= 1'b0;
      end else if (active_next == FULL) begin
        pwm_out <= 1'b1;
      end else begin
        pwm_out <= (cnt_next < active_next);
      end
    end
  end

endmodule

// File: rtl/pwm_rgb_16.sv
// Multi-channel PWM: shadow duty registers committed atomically at period wrap.
// Latency: write->shadow 1 clk; commit->commit_pending 1 clk; swap visible on period_start.
// Backpressure: load_ready drops while a commit is pending, freezing shadows until the swap.
module pwm_rgb_16
  import pwm_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int PRESCALE = PRESCALE_DEF,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    duty_in,
  input  logic [SEL_W-1:0]    chan_sel,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                commit,
  output logic                commit_pending,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  logic             tick;
  logic             wrap;
  logic             swap;
  logic             load_fire;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] shadow [CHANNELS];

  commit_state_t state;
  commit_state_t state_next;

  generate
    if (PRESCALE == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int              PW       = $clog2(PRESCALE);
      localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      assign tick = (pre == PRE_LAST);

      // Prescaler: free-running divider producing one tick every PRESCALE clocks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre <= '0;
        end else begin
          pre <= tick ? '0 : pre + PW'(1);
        end
      end
    end
  endgenerate

  assign cnt_next = tick ? cnt + WIDTH'(1) : cnt;
  assign wrap     = tick && (cnt == '1);

  // Period counter and the wrap pulse, registered so it aligns with pwm_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      period_start <= wrap;
    end
  end

  assign commit_pending = (state == PENDING);
  assign load_ready     = !commit_pending;
  assign load_fire      = load_valid && load_ready;

  // Shadow writes; an out-of-range chan_sel matches no channel and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) shadow[c] <= '0;
    end else if (load_fire) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(chan_sel) == c) shadow[c] <= duty_in;
      end
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Commit FSM next state: a commit arms the swap, which fires on the next wrap
  // seen while armed; a commit landing on a wrap therefore waits a full period.
  always_comb begin
    state_next = state;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_next = PENDING;
      end
      PENDING: begin
        if (wrap) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pwm_compare #(
        .WIDTH(WIDTH)
      ) u_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .swap    (swap),
        .shadow  (shadow[c]),
        .cnt_next(cnt_next),
        .pwm_out (pwm_out[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_rgb_16.sv
// Bench for pwm_rgb_16: directed scenarios plus random traffic against a period-level model.
// Main DUT runs WIDTH=8/PRESCALE=1; a second instance checks PRESCALE=4 timing.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_pwm_rgb_16;

  localparam int W   = 8;
  localparam int N   = 3;
  localparam int SW  = 2;
  localparam int PER = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [W-1:0]  duty_in;
  logic [SW-1:0] chan_sel;
  logic          load_valid, commit;
  logic          load_ready, commit_pending, period_start;
  logic [N-1:0]  pwm_out;

  logic [W-1:0]  duty4;
  logic [SW-1:0] sel4;
  logic          lv4, commit4;
  logic          rdy4, pend4, ps4;
  logic [N-1:0]  pwm4;

  always #5 clk = ~clk;

  pwm_rgb_16 #(.CHANNELS(N), .WIDTH(W), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .chan_sel(chan_sel),
    .load_valid(load_valid), .load_ready(load_ready), .commit(commit),
    .commit_pending(commit_pending), .period_start(period_start), .pwm_out(pwm_out)
  );

  pwm_rgb_16 #(.CHANNELS(N), .WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .duty_in(duty4), .chan_sel(sel4),
    .load_valid(lv4), .load_ready(rdy4), .commit(commit4),
    .commit_pending(pend4), .period_start(ps4), .pwm_out(pwm4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: k = clocks since reset release, so position in period = k % PER.
  int k;
  bit m_pend;
  int m_shadow[N];
  int m_active[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_pwm();
    logic [N-1:0] e;
    int pos;
    pos = k % PER;
    for (int c = 0; c < N; c++) e[c] = (m_active[c] == PER - 1) || (pos < m_active[c]);
    return e;
  endfunction

  task automatic model_edge();
    bit at_wrap, fire, do_swap;
    at_wrap = (k % PER) == PER - 1;
    fire    = load_valid && !m_pend;
    do_swap = m_pend && at_wrap;
    if (fire && int'(chan_sel) < N) m_shadow[int'(chan_sel)] = int'(duty_in);
    if (do_swap) m_active = m_shadow;
    m_pend = do_swap ? 1'b0 : (m_pend || commit);
    k++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pwm_out", pwm_out, exp_pwm());
    chk("period_start", period_start, (k > 0) && (k % PER == 0));
    chk("commit_pending", commit_pending, m_pend);
    chk("load_ready", load_ready, !m_pend);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_valid = 1'b0; commit = 1'b0; lv4 = 1'b0; commit4 = 1'b0;
    #2;
    chk("rst.pwm_out", pwm_out, 0);
    chk("rst.period_start", period_start, 0);
    chk("rst.commit_pending", commit_pending, 0);
    chk("rst.load_ready", load_ready, 1);
    chk("rst.pwm4", pwm4, 0);
    chk("rst.ready4", rdy4, 1);
    k = 0; m_pend = 1'b0;
    for (int c = 0; c < N; c++) begin m_shadow[c] = 0; m_active[c] = 0; end
    repeat (2) @(negedge clk);
    chk("rst.hold_pwm_out", pwm_out, 0);
    chk("rst.hold_pending", commit_pending, 0);
    rst_n = 1'b1;
  endtask

  task automatic write(input int ch, input int val);
    int n;
    n = 0;
    duty_in = W'(val); chan_sel = SW'(ch); load_valid = 1'b1;
    while (load_ready !== 1'b1 && n < 2 * PER + 4) begin cyc(); n++; end
    chk("write.ready_wait", load_ready, 1);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic commit_now();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin cyc(); n++; end while (period_start !== 1'b1 && n < 2 * PER + 4);
    chk("wait_ps.timeout", period_start, 1);
  endtask

  // Starts on a period_start sample, counts high clocks over one period, ends on the next.
  task automatic measure(input string tag, input int e0, input int e1, input int e2);
    int h[N];
    for (int c = 0; c < N; c++) h[c] = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) cyc();
      for (int c = 0; c < N; c++) h[c] += int'(pwm_out[c]);
    end
    cyc();
    chk({tag, ".spacing"}, period_start, 1);
    chk({tag, ".ch0_high"}, h[0], e0);
    chk({tag, ".ch1_high"}, h[1], e1);
    chk({tag, ".ch2_high"}, h[2], e2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h4[N];
    duty_in = '0; chan_sel = '0; load_valid = 1'b0; commit = 1'b0;
    duty4 = '0; sel4 = '0; lv4 = 1'b0; commit4 = 1'b0;

    do_reset();
    repeat (300) cyc();

    // Basic duty: 0, mid and full scale.
    write(0, 64); write(1, 0); write(2, 255);
    commit_now();
    wait_ps();
    measure("duty", 64, 0, 256);

    // Uncommitted write must not leak; commit mid-period lands at the wrap.
    write(0, 200);
    wait_ps();
    measure("nocommit", 64, 0, 256);
    repeat (10) cyc();
    commit_now();
    wait_ps();
    measure("atomic", 200, 0, 256);

    // Backpressure: write held off until the swap, then needs its own commit.
    commit_now();
    write(1, 99);
    wait_ps();
    measure("bp_nocommit", 200, 0, 256);
    commit_now();
    wait_ps();
    measure("bp_commit", 200, 99, 256);

    // Load and commit in the same cycle.
    duty_in = 8'd17; chan_sel = 2'd2; load_valid = 1'b1; commit = 1'b1;
    cyc();
    load_valid = 1'b0; commit = 1'b0;
    wait_ps();
    measure("ldcommit", 200, 99, 17);

    // Commit exactly on the wrap cycle defers the swap by one period.
    write(0, 5);
    n = 0;
    while ((k % PER) != PER - 1 && n < PER) begin cyc(); n++; end
    commit_now();
    chk("wrapcommit.pending", commit_pending, 1);
    measure("wrapdefer", 200, 99, 17);
    measure("wrapswap", 5, 99, 17);

    // Out-of-range channel: accepted and dropped.
    write(3, 170);
    commit_now();
    wait_ps();
    measure("badsel", 5, 99, 17);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 2) == 0);
      chan_sel   = SW'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       duty_in = '0;
        1:       duty_in = '1;
        default: duty_in = W'($urandom_range(0, 255));
      endcase
      commit = ($urandom_range(0, 63) == 0);
      cyc();
    end
    load_valid = 1'b0; commit = 1'b0;

    // Reset while a commit is pending drops it.
    commit_now();
    repeat (5) cyc();
    do_reset();
    repeat (20) cyc();

    // PRESCALE=4 instance: each count lasts 4 clocks, period is 1024 clocks.
    for (int c = 0; c < N; c++) begin
      sel4 = SW'(c);
      duty4 = (c == 0) ? 8'd128 : (c == 1) ? 8'd0 : 8'd255;
      lv4 = 1'b1;
      chk("p4.ready", rdy4, 1);
      cyc();
    end
    lv4 = 1'b0;
    commit4 = 1'b1;
    cyc();
    commit4 = 1'b0;
    chk("p4.pending", pend4, 1);
    n = 0;
    while (ps4 !== 1'b1 && n < 4 * PER + 8) begin cyc(); n++; end
    chk("p4.wait_ps", ps4, 1);
    for (int c = 0; c < N; c++) h4[c] = 0;
    for (int i = 0; i < 4 * PER; i++) begin
      if (i > 0) begin
        cyc();
        chk("p4.no_early_ps", ps4, 0);
      end
      for (int c = 0; c < N; c++) h4[c] += int'(pwm4[c]);
    end
    cyc();
    chk("p4.spacing", ps4, 1);
    chk("p4.pending_clear", pend4, 0);
    chk("p4.ch0_high", h4[0], 512);
    chk("p4.ch1_high", h4[1], 0);
    chk("p4.ch2_high", h4[2], 1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_rgb_16.md
# pwm_rgb_16

Multi-channel 16-bit PWM generator. Sits directly downstream of the 8→16-bit gamma correction LUT in the SPI blink path and turns corrected duty values into LED pin drive. Duty values are written per channel into shadow registers through a valid/ready port. A commit request copies all shadows into the active registers atomically at the next PWM period boundary, so a colour update never produces a torn period.

## Interface
Parameters:
- CHANNELS, 3: number of PWM outputs (R, G, B).
- WIDTH, 16: duty/counter width; matches the LUT output width.
- PRESCALE, 1: clocks per PWM count, ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- duty_in  in  WIDTH  corrected duty value from the LUT.
- chan_sel  in  max(1,$clog2(CHANNELS))  target shadow register.
- load_valid  in  1  duty_in/chan_sel valid.
- load_ready  out  1  shadow write accepted when valid&ready.
- commit  in  1  single-cycle request to transfer shadows to active at next wrap.
- commit_pending  out  1  commit requested, swap not yet done.
- period_start  out  1  one-cycle pulse on the cycle the counter wraps to 0.
- pwm_out  out  CHANNELS  registered PWM outputs.

## Operation
- Prescaler: `tick` is asserted every PRESCALE clocks. With PRESCALE=1, tick is constant high.
- Counter: WIDTH-bit `cnt` increments on tick and wraps from 2^WIDTH−1 to 0. `wrap` = tick && cnt==all-ones.
- Shadow write: on load_valid&&load_ready, `shadow[chan_sel] <= duty_in`.
  - chan_sel ≥ CHANNELS: the handshake completes and the data is dropped.
- load_ready = !commit_pending. Shadows are frozen between commit and swap.
- Commit FSM, two states:
  - IDLE: commit → PENDING.
  - PENDING: on wrap, active[] ← shadow[] (all channels, same cycle), then → IDLE.
  - commit while PENDING is ignored.
- Compare, per channel on the next clock:
  - active==0 → pwm_out low.
  - active==2^WIDTH−1 → pwm_out high for the full period (100%).
  - otherwise pwm_out = (cnt_next < active).
  - High time = active counts per 2^WIDTH-count period.
- period_start is a registered copy of `wrap`.

## Timing
- Reset values: cnt=0, prescaler=0, shadow[]=0, active[]=0, pwm_out=0, load_ready=1, commit_pending=0, period_start=0, FSM=IDLE.
- Latency, write→shadow: 1 clock.
- Latency, commit→commit_pending high: 1 clock.
- Latency, swap→pwm_out reflecting new duty: the first count of the new period. pwm_out and period_start are aligned, both asserting on the clock after `wrap`.
- load_valid and commit in the same cycle with ready=1: the write is accepted and included in the commit.
- commit on the same cycle as `wrap`: the swap does not occur on that wrap; it occurs on the following wrap (worst case 2^WIDTH·PRESCALE clocks).
- commit_pending falls on the clock after the swap cycle; load_ready rises with it.
- Reset mid-period or mid-pending: everything returns immediately to reset values. The pending commit is lost.
- Active values change only on `wrap`; pwm_out never glitches mid-period.

## Structure
- Package `pwm_pkg`:
  - default CHANNELS, WIDTH, PRESCALE constants.
  - commit FSM state enum (IDLE, PENDING).
  - helper localparam DUTY_MAX = 2^WIDTH−1.
- Sub-module `pwm_compare`, instantiated per channel: active register plus the 0/max/compare logic, driving one pwm_out bit.
- Top level holds the prescaler, counter, shadows, and commit FSM.

## Test plan
All directed tests use WIDTH=8, PRESCALE=1 unless stated.
- Reset: hold rst_n=0 mid-run → all outputs 0, load_ready=1; release → cnt counts 0,1,2…, period_start pulses every 256 clocks.
- Duty check: write ch0=64, ch1=0, ch2=255, then commit → after the swap, per period ch0 high 64/256 clocks, ch1 never high, ch2 high 256/256.
- Atomic update: ch0=64 active; write ch0=200 with no commit → duty stays 64; commit at cnt=10 → duty 64 until wrap, then 200 from the next period start.
- Backpressure: commit, then load_valid=1 with ch1=99 → load_ready=0 until the swap and the write is not taken; after ready rises, the write lands; ch1 changes only after a second commit.
- Edge events:
  - load and commit in the same cycle → the value is included.
  - commit on the wrap cycle → swap deferred one full period.
  - chan_sel=3 → handshake completes, no register changes.
- PRESCALE=4, WIDTH=16: duty 32768 → pwm_out high exactly 131072 of 262144 clocks; period_start spacing 262144 clocks.
